filter_inst_decoder: RTL and testbench
======================================

Name: filter_inst_decoder

Overview:
- Receive end of the filter-instruction packet stream.
- Sits at the PE/filter-buffer side, behind the FIFO that carries packets from the filter instruction generator.
- Checks each packet against the configured filter size, presents one decoded row-load command per valid packet, and flags protocol violations.
- Clocked RTL with valid/ready handshakes on every channel.

Parameters:
- WIDTH, 15: packet width.
- IDX_W, 3: width of the row-index and size fields.
- TYPE_BIT, 0: packet bit that must be 1 for a filter instruction.
- IDX_LSB, 1: LSB of the row-index field, which occupies bits [IDX_LSB+IDX_W-1:IDX_LSB], default [3:1].
- LAST_BIT, 14: last-row flag bit.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- cfg_valid  in  1  filter-size config offered
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready
- cfg_size  in  IDX_W  number of filter rows, 0..7
- in_valid  in  1  packet offered
- in_ready  out  1  packet accepted when in_valid && in_ready
- in_data  in  WIDTH  instruction packet
- row_valid  out  1  decoded row command valid
- row_ready  in  1  downstream accepts row command
- row_idx  out  IDX_W  row index to load
- row_last  out  1  final row of the filter
- done  out  1  one-cycle pulse when the sequence completes
- done_count  out  IDX_W  rows delivered, valid while done=1
- err  out  1  sticky protocol error
- err_code  out  2  1=bad type, 2=index out of order, 3=early last flag
- err_clr  in  1  clears the error, honoured only in ERR

Behaviour:
- Reset (rst_n=0 at a posedge):
  - State goes to IDLE.
  - All outputs go to 0: cfg_ready, in_ready, row_valid, row_idx, row_last, done, done_count, err, err_code.
  - Internal size, expected-index and count registers clear.
  - Reset mid-sequence discards any pending row, including one already presented.
- Output row register: one entry.
  - row_valid, once set, stays set with row_idx/row_last stable until row_valid && row_ready.
- States: IDLE, RECV, DRAIN, ERR.
- IDLE:
  - cfg_ready=1, in_ready=0.
  - On cfg accept with cfg_size=0: done=1 and done_count=0 next cycle; stay in IDLE.
  - On cfg accept with cfg_size>0: latch size, set exp=0, go to RECV.
- RECV:
  - in_ready = !row_valid || row_ready.
  - A packet is accepted and the consumed row released in the same cycle when both handshakes fire. Throughput is 1 packet/cycle.
  - Checks on an accepted packet, in priority order:
    - in_data[TYPE_BIT]=0 gives code 1.
    - idx != exp gives code 2.
    - in_data[LAST_BIT]=1 with idx != size-1 gives code 3.
  - Any failed check: next cycle err=1 with err_code set, go to ERR, row register not loaded.
  - Passing packet: next cycle row_valid=1, row_idx=idx, row_last=(idx==size-1), exp++.
  - If idx==size-1, go to DRAIN.
  - LAST_BIT=0 on the final index is legal. Termination is by count.
  - Other packet bits are ignored.
- DRAIN:
  - in_ready=0, cfg_ready=0.
  - When the final row handshake completes: done=1 and done_count=size in the following cycle, state returns to IDLE in that same cycle.
- ERR:
  - cfg_ready=0, in_ready=0.
  - A pending valid row still completes its handshake normally.
  - err and err_code hold until err_clr=1. The next cycle clears err/err_code and goes to IDLE.
  - err_clr is ignored in every state other than ERR.
- Latency: packet accept to row_valid is 1 cycle. Final row handshake to done is 1 cycle.
- cfg_valid outside IDLE is ignored (cfg_ready=0); no error is raised.
- exp is IDX_W+1 bits wide, so no wrap: size 7 accepts indices 0..6.

Test Plan:
- cfg_size=3, then packets 0x0001, 0x0003, 0x0005, row_ready=1 -> row_idx 0,1,2 on consecutive cycles, row_last only on idx 2, done=1 with done_count=3 one cycle after the last row handshake.
- cfg_size=3, row_ready held 0 for 4 cycles after the first row -> in_ready=0 while stalled, row_idx=0 stable, no packet lost, sequence completes after release.
- cfg_size=0 -> done=1, done_count=0 the cycle after config; in_ready never asserts.
- cfg_size=4, packets idx 0 then idx 2 (0x0005) -> err=1, err_code=2, row 0 still delivered, no row for idx 2; err_clr -> IDLE, cfg_ready=1.
- cfg_size=4, packet 0x0002 (type bit 0) -> err_code=1. Separate run: packet 0x4001 (last flag on idx 0) -> err_code=3.
- rst_n=0 while in RECV with row_valid=1 -> all outputs 0 next cycle, state IDLE. A new cfg_size=2 sequence then completes normally.

Source files
------------

// File: rtl/filter_inst_decoder.sv
// Receive-side decoder for filter-instruction packets: validates each packet
// against the configured filter size and emits one row-load command per packet.
module filter_inst_decoder #(
  parameter int WIDTH    = 15,
  parameter int IDX_W    = 3,
  parameter int TYPE_BIT = 0,
  parameter int IDX_LSB  = 1,
  parameter int LAST_BIT = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [IDX_W-1:0] cfg_size,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             row_valid,
  input  logic             row_ready,
  output logic [IDX_W-1:0] row_idx,
  output logic             row_last,
  output logic             done,
  output logic [IDX_W-1:0] done_count,
  output logic             err,
  output logic [1:0]       err_code,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    DRAIN = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t           state, state_nx;
  logic [IDX_W-1:0] size_q;
  logic [IDX_W:0]   exp_q;
  logic [IDX_W-1:0] cnt_q;

  logic             cfg_fire, in_fire, row_fire;
  logic [IDX_W-1:0] pkt_idx, last_idx;
  logic             pkt_type, pkt_last, idx_is_last;
  logic [1:0]       chk_code;
  logic             unused_pkt_bits;

  assign cfg_fire = cfg_valid && cfg_ready;
  assign row_fire = row_valid && row_ready;
  assign in_fire  = in_valid && in_ready;

  // Fields outside type/index/last carry no meaning for this block.
  assign unused_pkt_bits = ^in_data;

  always_comb begin
    state_nx    = state;
    in_ready    = 1'b0;
    chk_code    = '0;
    pkt_idx     = in_data[IDX_LSB +: IDX_W];
    pkt_type    = in_data[TYPE_BIT];
    pkt_last    = in_data[LAST_BIT];
    last_idx    = size_q - IDX_W'(1);
    idx_is_last = (pkt_idx == last_idx);

    if (!pkt_type)
      chk_code = 2'd1;
    else if ({1'b0, pkt_idx} != exp_q)
      chk_code = 2'd2;
    else if (pkt_last && !idx_is_last)
      chk_code = 2'd3;

    case (state)
      IDLE: begin
        if (cfg_fire && (cfg_size != '0))
          state_nx = RECV;
      end
      RECV: begin
        // The single row slot frees in the same cycle it is consumed.
        in_ready = !row_valid || row_ready;
        if (in_valid && in_ready) begin
          if (chk_code != 2'd0)
            state_nx = ERR;
          else if (idx_is_last)
            state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (row_fire)
          state_nx = IDLE;
      end
      ERR: begin
        if (err_clr)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_ready  <= 1'b0;
      row_valid  <= 1'b0;
      row_idx    <= '0;
      row_last   <= 1'b0;
      done       <= 1'b0;
      done_count <= '0;
      err        <= 1'b0;
      err_code   <= '0;
      size_q     <= '0;
      exp_q      <= '0;
      cnt_q      <= '0;
    end else begin
      cfg_ready  <= (state_nx == IDLE);
      done       <= 1'b0;
      done_count <= '0;

      if (row_fire) begin
        row_valid <= 1'b0;
        cnt_q     <= cnt_q + IDX_W'(1);
      end

      if ((state == IDLE) && cfg_fire) begin
        size_q <= cfg_size;
        exp_q  <= '0;
        cnt_q  <= '0;
        if (cfg_size == '0)
          done <= 1'b1;
      end

      if ((state == RECV) && in_fire) begin
        if (chk_code == 2'd0) begin
          row_valid <= 1'b1;
          row_idx   <= pkt_idx;
          row_last  <= idx_is_last;
          exp_q     <= exp_q + (IDX_W+1)'(1);
        end else begin
          err      <= 1'b1;
          err_code <= chk_code;
        end
      end

      // The final handshake itself counts toward the delivered total.
      if ((state == DRAIN) && row_fire) begin
        done       <= 1'b1;
        done_count <= cnt_q + IDX_W'(1);
      end

      if ((state == ERR) && err_clr) begin
        err      <= 1'b0;
        err_code <= '0;
      end
    end
  end

endmodule

// File: tb/tb_filter_inst_decoder.sv
// Directed bench for filter_inst_decoder: a cycle model checked every negedge
// plus literal expectations for each scenario.
module tb_filter_inst_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [2:0]  cfg_size;
  logic        in_valid, in_ready;
  logic [14:0] in_data;
  logic        row_valid, row_ready;
  logic [2:0]  row_idx;
  logic        row_last;
  logic        done;
  logic [2:0]  done_count;
  logic        err;
  logic [1:0]  err_code;
  logic        err_clr;

  filter_inst_decoder #(
    .WIDTH(15), .IDX_W(3), .TYPE_BIT(0), .IDX_LSB(1), .LAST_BIT(14)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_size(cfg_size),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .row_valid(row_valid), .row_ready(row_ready), .row_idx(row_idx), .row_last(row_last),
    .done(done), .done_count(done_count),
    .err(err), .err_code(err_code), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. phase: 0 waiting for config, 1 collecting packets,
  // 2 waiting for last row to leave, 3 faulted.
  typedef struct {
    int phase; int size; int nxt; int dlv;
    bit cfg_rdy; bit rv; int ridx; bit rlast;
    bit done; int dcnt; bit err; int code;
  } mdl_t;

  mdl_t m;
  bit   live = 0;

  always @(posedge clk) begin : model
    mdl_t n;
    bit   irdy, cf, inf, rf;
    int   idx, code;
    n = m;
    if (!rst_n) begin
      n = '{default: 0};
    end else begin
      irdy = (m.phase == 1) && (!m.rv || row_ready);
      cf   = cfg_valid && m.cfg_rdy;
      inf  = in_valid && irdy;
      rf   = m.rv && row_ready;
      n.done = 0;
      n.dcnt = 0;
      if (rf) begin
        n.rv  = 0;
        n.dlv = m.dlv + 1;
      end
      case (m.phase)
        0: if (cf) begin
          if (cfg_size == 0) n.done = 1;
          else begin
            n.size = int'(cfg_size); n.nxt = 0; n.dlv = 0; n.phase = 1;
          end
        end
        1: if (inf) begin
          idx = int'(in_data[3:1]);
          if (!in_data[0])                           code = 1;
          else if (idx != m.nxt)                     code = 2;
          else if (in_data[14] && idx != m.size - 1) code = 3;
          else                                       code = 0;
          if (code != 0) begin
            n.err = 1; n.code = code; n.phase = 3;
          end else begin
            n.rv = 1; n.ridx = idx; n.rlast = (idx == m.size - 1); n.nxt = m.nxt + 1;
            if (idx == m.size - 1) n.phase = 2;
          end
        end
        2: if (rf) begin
          n.done = 1; n.dcnt = m.dlv + 1; n.phase = 0;
        end
        3: if (err_clr) begin
          n.err = 0; n.code = 0; n.phase = 0;
        end
        default: n.phase = 0;
      endcase
      n.cfg_rdy = (n.phase == 0);
    end
    m    <= n;
    live <= 1'b1;
  end

  always @(negedge clk) begin : compare
    if (live) begin
      chk("cfg_ready", cfg_ready, m.cfg_rdy);
      chk("in_ready", in_ready, (m.phase == 1) && (!m.rv || row_ready));
      chk("row_valid", row_valid, m.rv);
      if (m.rv) begin
        chk("row_idx", row_idx, m.ridx);
        chk("row_last", row_last, m.rlast);
      end
      chk("done", done, m.done);
      if (m.done) chk("done_count", done_count, m.dcnt);
      chk("err", err, m.err);
      chk("err_code", err_code, m.code);
    end
  end

  // Event log for the literal scenario checks (row indices folded base 8).
  int cyc = 0, n_rows = 0, row_fold = 0, last_fold = 0, last_row_cyc = 0, max_gap = 0;
  int n_done = 0, done_val = -1, done_cyc = 0, n_acc = 0, in_rdy_seen = 0;

  always @(negedge clk) begin : monitor
    cyc++;
    if (row_valid && row_ready) begin
      if (n_rows > 0 && (cyc - last_row_cyc) > max_gap) max_gap = cyc - last_row_cyc;
      n_rows++;
      row_fold     = row_fold * 8 + int'(row_idx);
      last_fold    = last_fold * 2 + int'(row_last);
      last_row_cyc = cyc;
    end
    if (done) begin
      n_done++; done_val = int'(done_count); done_cyc = cyc;
    end
    if (in_valid && in_ready) n_acc++;
    if (in_ready) in_rdy_seen++;
  end

  task automatic clear_log();
    n_rows = 0; row_fold = 0; last_fold = 0; max_gap = 0;
    n_done = 0; done_val = -1; n_acc = 0; in_rdy_seen = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_cfg(input int sz);
    bit ok = 0;
    cfg_valid = 1'b1;
    cfg_size  = sz[2:0];
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = cfg_ready;
      tick();
    end
    cfg_valid = 1'b0;
    chk("cfg_accept", ok, 1);
  endtask

  task automatic send_pkt(input int d);
    bit ok = 0;
    in_valid = 1'b1;
    in_data  = d[14:0];
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    chk("pkt_accept", ok, 1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_cfg_ready"}, cfg_ready, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_row_valid"}, row_valid, 0);
    chk({tag, "_row_idx"}, row_idx, 0);
    chk({tag, "_row_last"}, row_last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_done_count"}, done_count, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n = 1'b0; cfg_valid = 0; cfg_size = '0; in_valid = 0; in_data = '0;
    row_ready = 0; err_clr = 0;
    tick(); tick();
    @(negedge clk);
    chk_all_zero("rst");
    tick();
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_cfg_ready", cfg_ready, 1);
    tick();

    // Basic size-3 sequence at full throughput.
    row_ready = 1'b1;
    clear_log();
    send_cfg(3);
    send_pkt('h0001); send_pkt('h0003); send_pkt('h0005);
    idle(4);
    chk("A_nrows", n_rows, 3);
    chk("A_rows", row_fold, 'o012);
    chk("A_last", last_fold, 'b001);
    chk("A_gap", max_gap, 1);
    chk("A_ndone", n_done, 1);
    chk("A_done_count", done_val, 3);
    chk("A_done_lat", done_cyc - last_row_cyc, 1);

    // Downstream stall after the first row.
    row_ready = 1'b0;
    clear_log();
    send_cfg(3);
    send_pkt('h0001);
    in_valid = 1'b1; in_data = 15'h0003;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("B_stall_in_ready", in_ready, 0);
      chk("B_stall_row_idx", row_idx, 0);
      tick();
    end
    row_ready = 1'b1;
    send_pkt('h0003); send_pkt('h0005);
    idle(4);
    chk("B_nacc", n_acc, 3);
    chk("B_rows", row_fold, 'o012);
    chk("B_done_count", done_val, 3);

    // Zero-size filter completes immediately; err_clr is ignored outside ERR.
    err_clr = 1'b1;
    clear_log();
    send_cfg(0);
    @(negedge clk);
    chk("C_done", done, 1);
    chk("C_done_count", done_count, 0);
    tick(); idle(3);
    @(negedge clk);
    chk("C_in_ready_seen", in_rdy_seen, 0);
    chk("C_ndone", n_done, 1);
    chk("C_err", err, 0);
    err_clr = 1'b0;
    tick();

    // Out-of-order index: row 0 still delivered, idx 2 never appears.
    clear_log();
    send_cfg(4);
    send_pkt('h0001); send_pkt('h0005);
    @(negedge clk);
    chk("D_err", err, 1);
    chk("D_err_code", err_code, 2);
    tick(); idle(2);
    chk("D_nrows", n_rows, 1);
    chk("D_rows", row_fold, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    @(negedge clk);
    chk("D_clr_cfg_ready", cfg_ready, 1);
    chk("D_clr_err", err, 0);
    tick();

    // Bad type bit.
    clear_log();
    send_cfg(4);
    send_pkt('h0002);
    @(negedge clk);
    chk("E1_err_code", err_code, 1);
    tick(); idle(2);
    chk("E1_nrows", n_rows, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0;

    // Early last flag on index 0.
    send_cfg(4);
    send_pkt('h4001);
    @(negedge clk);
    chk("E2_err_code", err_code, 3);
    tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    idle(2);

    // Reset while a row is being presented, then a clean size-2 run.
    row_ready = 1'b0;
    send_cfg(3);
    send_pkt('h0001);
    @(negedge clk);
    chk("F_pending_row", row_valid, 1);
    tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    chk_all_zero("F_rst");
    tick();
    rst_n = 1'b1;
    tick();
    row_ready = 1'b1;
    clear_log();
    send_cfg(2);
    send_pkt('h0001); send_pkt('h0003);
    idle(4);
    chk("F_nrows", n_rows, 2);
    chk("F_rows", row_fold, 'o01);
    chk("F_last", last_fold, 'b01);
    chk("F_done_count", done_val, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
